// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter and its picker.
// The picker is also meant for the planned I/O-port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_CH     = 8;

    // Width of an index/counter covering 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: fixed priority (lowest index) or round-robin
// search starting at ptr with wrap-around.
module arb_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [IDX_W-1:0]  grant,
    output logic              valid
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode == 1'(ARB_RR)) begin
                // ptr < NUM_CH and k < NUM_CH, so one subtraction wraps it.
                cand = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (cand >= (IDX_W + 1)'(NUM_CH)) begin
                    cand = cand - (IDX_W + 1)'(NUM_CH);
                end
            end else begin
                cand = (IDX_W + 1)'(k);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                grant = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates NUM_CH pipeline clients onto one asynchronous single-port SRAM
// with a registered IDLE/ACCESS/DONE timing FSM; tristate stays at top level.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int ARB_MODE    = ARB_FIXED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        busy,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_dq_o,
    output logic                     sram_dq_oe,
    input  logic [DATA_W-1:0]        sram_dq_i,
    output logic                     sram_en_n,
    output logic                     sram_oe_n,
    output logic                     sram_we_n,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = idx_w(NUM_CH);
    localparam int CNT_W = idx_w(WAIT_CYCLES);

    // Handshake: a client raises req[i] (with we/addr/wdata stable) and holds it
    // until ack[i] pulses for one cycle. Once granted the access is committed and
    // completes even if req[i] falls; ungranted requests simply keep waiting.

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   gnt_q;
    logic [IDX_W-1:0]   ptr;
    logic               op_we;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [IDX_W-1:0]   ptr_next;

    arb_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .mode  (ARB_MODE == ARB_RR),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    assign ptr_next  = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + IDX_W'(1);
    assign busy      = req & ~ack;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            gnt_q      <= '0;
            ptr        <= '0;
            op_we      <= 1'b0;
            ack        <= '0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_en_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q      <= pick_idx;
                        op_we      <= we[pick_idx];
                        sram_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        sram_dq_o  <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        sram_en_n  <= 1'b0;
                        sram_oe_n  <= we[pick_idx];
                        sram_we_n  <= ~we[pick_idx];
                        sram_dq_oe <= we[pick_idx];
                        if (ARB_MODE == ARB_RR) begin
                            ptr <= ptr_next;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        sram_en_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (!op_we) begin
                            rdata <= sram_dq_i;
                        end
                        ack[gnt_q] <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Write data was held one cycle past WE rising; release the bus.
                    sram_dq_oe <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a 2-channel fixed-priority instance (WAIT=1) and
// a 3-channel round-robin instance (WAIT=3), each on its own SRAM bus model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int NA = 2;
    localparam int WA = 1;
    localparam int NB = 3;
    localparam int WB = 3;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [NA-1:0]    req_a, we_a, ack_a, busy_a;
    logic [NA*AW-1:0] addr_a;
    logic [NA*DW-1:0] wdata_a;
    logic [DW-1:0]    rdata_a, dq_o_a, dq_i_a;
    logic [AW-1:0]    saddr_a;
    logic             dq_oe_a, en_n_a, oe_n_a, we_n_a;
    logic [1:0]       st_a;

    logic [NB-1:0]    req_b, we_b, ack_b, busy_b;
    logic [NB*AW-1:0] addr_b;
    logic [NB*DW-1:0] wdata_b;
    logic [DW-1:0]    rdata_b, dq_o_b, dq_i_b;
    logic [AW-1:0]    saddr_b;
    logic             dq_oe_b, en_n_b, oe_n_b, we_n_b;
    logic [1:0]       st_b;

    sram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NA), .WAIT_CYCLES(WA), .ARB_MODE(ARB_FIXED)
    ) u_fix (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .sram_addr(saddr_a),
        .sram_dq_o(dq_o_a), .sram_dq_oe(dq_oe_a), .sram_dq_i(dq_i_a),
        .sram_en_n(en_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .dbg_state(st_a)
    );

    sram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NB), .WAIT_CYCLES(WB), .ARB_MODE(ARB_RR)
    ) u_rr (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .sram_addr(saddr_b),
        .sram_dq_o(dq_o_b), .sram_dq_oe(dq_oe_b), .sram_dq_i(dq_i_b),
        .sram_en_n(en_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .dbg_state(st_b)
    );

    // ---------------- SRAM chip models ----------------
    logic [DW-1:0] mem_a [logic [AW-1:0]];
    logic [DW-1:0] mem_b [logic [AW-1:0]];
    logic [DW-1:0] exp_mem_b [logic [AW-1:0]];

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function logic [DW-1:0] rd_a(input logic [AW-1:0] a);
        return mem_a.exists(a) ? mem_a[a] : dflt(a);
    endfunction

    function logic [DW-1:0] rd_b(input logic [AW-1:0] a);
        return mem_b.exists(a) ? mem_b[a] : dflt(a);
    endfunction

    function logic [DW-1:0] exp_rd_b(input logic [AW-1:0] a);
        return exp_mem_b.exists(a) ? exp_mem_b[a] : dflt(a);
    endfunction

    always @(negedge clk) begin
        dq_i_a = (!oe_n_a && !en_n_a) ? rd_a(saddr_a) : 16'h0000;
        dq_i_b = (!oe_n_b && !en_n_b) ? rd_b(saddr_b) : 16'h0000;
    end

    always @(posedge clk) begin
        if (!en_n_a && !we_n_a) mem_a[saddr_a] = dq_o_a;
        if (!en_n_b && !we_n_b) mem_b[saddr_b] = dq_o_b;
    end

    // Output enable and data drive must never overlap on either bus.
    always @(negedge clk) begin
        total++;
        if (!oe_n_a && dq_oe_a) begin
            bad++;
            $display("FAIL bus_contention_a t=%0t oe_n=%b dq_oe=%b", $time, oe_n_a, dq_oe_a);
        end
        total++;
        if (!oe_n_b && dq_oe_b) begin
            bad++;
            $display("FAIL bus_contention_b t=%0t oe_n=%b dq_oe=%b", $time, oe_n_b, dq_oe_b);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        total++; if (ack_a !== 2'b00) begin bad++; $display("FAIL rst_ack_a got=%b exp=00", ack_a); end
        total++; if (rdata_a !== 16'h0) begin bad++; $display("FAIL rst_rdata_a got=%h exp=0000", rdata_a); end
        total++; if ({en_n_a, oe_n_a, we_n_a} !== 3'b111) begin bad++; $display("FAIL rst_strobes_a got=%b exp=111", {en_n_a, oe_n_a, we_n_a}); end
        total++; if (dq_oe_a !== 1'b0) begin bad++; $display("FAIL rst_dq_oe_a got=%b exp=0", dq_oe_a); end
        total++; if (saddr_a !== 18'h0 || dq_o_a !== 16'h0) begin bad++; $display("FAIL rst_addr_data_a got=%h/%h exp=0/0", saddr_a, dq_o_a); end
        total++; if (st_a !== IDLE) begin bad++; $display("FAIL rst_state_a got=%0d exp=%0d", st_a, IDLE); end
        total++; if (ack_b !== 3'b000 || rdata_b !== 16'h0) begin bad++; $display("FAIL rst_ack_rdata_b got=%b/%h exp=000/0000", ack_b, rdata_b); end
        total++; if ({en_n_b, oe_n_b, we_n_b, dq_oe_b} !== 4'b1110) begin bad++; $display("FAIL rst_strobes_b got=%b exp=1110", {en_n_b, oe_n_b, we_n_b, dq_oe_b}); end
        total++; if (st_b !== IDLE) begin bad++; $display("FAIL rst_state_b got=%0d exp=%0d", st_b, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int t_ack = -1;
        int n_oe  = 0;
        mem_a[18'h00010] = 16'hBEEF;
        req_a = 2'b01; we_a = 2'b00; addr_a[0 +: AW] = 18'h00010;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (!oe_n_a) n_oe++;
            if (i == 1) begin
                total++; if (st_a !== ACCESS) begin bad++; $display("FAIL rd_state got=%0d exp=%0d", st_a, ACCESS); end
                total++; if (saddr_a !== 18'h00010) begin bad++; $display("FAIL rd_addr got=%h exp=00010", saddr_a); end
                total++; if (busy_a !== 2'b01) begin bad++; $display("FAIL rd_busy got=%b exp=01", busy_a); end
            end
            if (ack_a[0] && t_ack < 0) begin
                t_ack = i;
                total++; if (rdata_a !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", rdata_a); end
                req_a = 2'b00;
            end
        end
        total++; if (t_ack != 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", t_ack); end
        total++; if (n_oe != WA) begin bad++; $display("FAIL rd_oe_cycles got=%0d exp=%0d", n_oe, WA); end
        total++; if (st_a !== IDLE) begin bad++; $display("FAIL rd_back_idle got=%0d exp=%0d", st_a, IDLE); end
    endtask

    task automatic test_single_write();
        int t_ack = -1;
        int n_we = 0;
        int n_oe = 0;
        req_a = 2'b10; we_a = 2'b10;
        addr_a[AW +: AW] = 18'h3FFFF; wdata_a[DW +: DW] = 16'h1234;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!we_n_a) n_we++;
            if (dq_oe_a) n_oe++;
            if (!en_n_a) begin
                total++; if (saddr_a !== 18'h3FFFF || dq_o_a !== 16'h1234) begin bad++; $display("FAIL wr_addr_data got=%h/%h exp=3ffff/1234", saddr_a, dq_o_a); end
            end
            if (ack_a[1] && t_ack < 0) begin
                t_ack = i;
                req_a = 2'b00; we_a = 2'b00;
            end
        end
        total++; if (t_ack != WA + 1) begin bad++; $display("FAIL wr_ack_time got=%0d exp=%0d", t_ack, WA + 1); end
        total++; if (n_we != WA) begin bad++; $display("FAIL wr_we_cycles got=%0d exp=%0d", n_we, WA); end
        total++; if (n_oe != WA + 1) begin bad++; $display("FAIL wr_dq_oe_cycles got=%0d exp=%0d", n_oe, WA + 1); end
        total++; if (rd_a(18'h3FFFF) !== 16'h1234) begin bad++; $display("FAIL wr_mem got=%h exp=1234", rd_a(18'h3FFFF)); end
    endtask

    task automatic test_fixed_priority();
        int t0 = -1;
        int t1 = -1;
        mem_a[18'h20] = 16'hC0DE;
        mem_a[18'h21] = 16'h7E57;
        req_a = 2'b11; we_a = 2'b00;
        addr_a[0 +: AW] = 18'h20; addr_a[AW +: AW] = 18'h21;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_a[0] && t0 < 0) begin
                t0 = i; req_a[0] = 1'b0;
                total++; if (rdata_a !== 16'hC0DE) begin bad++; $display("FAIL fp_rdata0 got=%h exp=c0de", rdata_a); end
            end
            if (ack_a[1] && t1 < 0) begin
                t1 = i; req_a[1] = 1'b0;
                total++; if (rdata_a !== 16'h7E57) begin bad++; $display("FAIL fp_rdata1 got=%h exp=7e57", rdata_a); end
            end else if (t1 < 0) begin
                total++; if (busy_a[1] !== 1'b1) begin bad++; $display("FAIL fp_busy1 cyc=%0d got=%b exp=1", i, busy_a[1]); end
            end
        end
        total++; if (t0 != WA + 1) begin bad++; $display("FAIL fp_ack0_time got=%0d exp=%0d", t0, WA + 1); end
        total++; if (t1 != t0 + WA + 2) begin bad++; $display("FAIL fp_ack1_time got=%0d exp=%0d", t1, t0 + WA + 2); end
    endtask

    task automatic test_reset_mid_write();
        int t_ack = -1;
        req_a = 2'b01; we_a = 2'b01;
        addr_a[0 +: AW] = 18'h5; wdata_a[0 +: DW] = 16'hAAAA;
        @(negedge clk);
        total++; if (st_a !== ACCESS || we_n_a !== 1'b0) begin bad++; $display("FAIL rmw_in_access got=%0d/%b exp=%0d/0", st_a, we_n_a, ACCESS); end
        rst = 1'b1; req_a = 2'b00; we_a = 2'b00;
        @(negedge clk);
        total++; if (we_n_a !== 1'b1 || en_n_a !== 1'b1) begin bad++; $display("FAIL rmw_strobes got=%b/%b exp=1/1", we_n_a, en_n_a); end
        total++; if (dq_oe_a !== 1'b0) begin bad++; $display("FAIL rmw_dq_oe got=%b exp=0", dq_oe_a); end
        total++; if (ack_a !== 2'b00) begin bad++; $display("FAIL rmw_ack got=%b exp=00", ack_a); end
        total++; if (st_a !== IDLE) begin bad++; $display("FAIL rmw_state got=%0d exp=%0d", st_a, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (ack_a !== 2'b00) begin bad++; $display("FAIL rmw_late_ack got=%b exp=00", ack_a); end
        mem_a[18'h44] = 16'h0F0F;
        req_a = 2'b10; we_a = 2'b00; addr_a[AW +: AW] = 18'h44;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (ack_a[1] && t_ack < 0) begin
                t_ack = i; req_a = 2'b00;
                total++; if (rdata_a !== 16'h0F0F) begin bad++; $display("FAIL rmw_fresh_rdata got=%h exp=0f0f", rdata_a); end
            end
        end
        total++; if (t_ack != WA + 1) begin bad++; $display("FAIL rmw_fresh_ack got=%0d exp=%0d", t_ack, WA + 1); end
    endtask

    task automatic test_round_robin();
        int order[6];
        int times[6];
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        int n = 0;
        int ch;
        req_b = 3'b111; we_b = 3'b000;
        addr_b[0 +: AW] = 18'h1; addr_b[AW +: AW] = 18'h2; addr_b[2*AW +: AW] = 18'h3;
        for (int i = 1; i <= 40 && n < 6; i++) begin
            @(negedge clk);
            if (ack_b != '0) begin
                total++; if (!$onehot(ack_b)) begin bad++; $display("FAIL rr_onehot got=%b", ack_b); end
                ch = 0;
                for (int c = 0; c < NB; c++) if (ack_b[c]) ch = c;
                total++; if (rdata_b !== rd_b(addr_b[ch*AW +: AW])) begin bad++; $display("FAIL rr_rdata ch=%0d got=%h exp=%h", ch, rdata_b, rd_b(addr_b[ch*AW +: AW])); end
                order[n] = ch; times[n] = i; n++;
                if (n == 6) req_b = '0;
            end
        end
        req_b = '0;
        total++; if (n != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", n); end
        for (int k = 0; k < n; k++) begin
            total++; if (order[k] != exp_order[k]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k], exp_order[k]); end
            if (k == 0) begin
                total++; if (times[0] != WB + 1) begin bad++; $display("FAIL rr_first_ack got=%0d exp=%0d", times[0], WB + 1); end
            end else begin
                total++; if (times[k] - times[k-1] != WB + 2) begin bad++; $display("FAIL rr_spacing idx=%0d got=%0d exp=%0d", k, times[k] - times[k-1], WB + 2); end
            end
        end
        repeat (WB + 3) @(negedge clk);
    endtask

    task automatic test_req_dropped();
        int n_oe = 0;
        int n_ack = 0;
        int t_ack = -1;
        req_b = 3'b001; we_b = 3'b000; addr_b[0 +: AW] = 18'h7;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) req_b = 3'b000;
            if (!oe_n_b) n_oe++;
            if (ack_b[0]) begin
                n_ack++; t_ack = i;
                total++; if (rdata_b !== rd_b(18'h7)) begin bad++; $display("FAIL drop_rdata got=%h exp=%h", rdata_b, rd_b(18'h7)); end
            end
        end
        total++; if (n_oe != WB) begin bad++; $display("FAIL drop_oe_cycles got=%0d exp=%0d", n_oe, WB); end
        total++; if (n_ack != 1) begin bad++; $display("FAIL drop_ack_count got=%0d exp=1", n_ack); end
        total++; if (t_ack != WB + 1) begin bad++; $display("FAIL drop_ack_time got=%0d exp=%0d", t_ack, WB + 1); end
    endtask

    // Transaction-level model: the chip is free every WAIT+2 cycles, a grant at
    // edge g owns the strobes for WAIT cycles and acks WAIT cycles later.
    task automatic test_random_rr(input int ncyc);
        logic [NB-1:0] pend;
        logic [NB-1:0] cw;
        logic [AW-1:0] ca [NB];
        logic [DW-1:0] cd [NB];
        int            gap [NB];
        int            m_free = 0;
        int            m_g = -100;
        int            m_ack = -1;
        int            m_ch = 0;
        int            ptr = 0;
        int            g;
        logic          m_we = 1'b0;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wd = '0;
        logic [NB-1:0] exp_ack;
        logic          in_acc;

        pend = '0; cw = '0;
        for (int c = 0; c < NB; c++) begin ca[c] = '0; cd[c] = '0; gap[c] = 0; end
        mem_b.delete();
        exp_mem_b.delete();
        rst = 1'b1; req_b = '0; we_b = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            exp_ack = (i == m_ack) ? (NB'(1) << m_ch) : '0;
            in_acc = (i >= m_g) && (i < m_g + WB);
            total++; if (ack_b !== exp_ack) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", i, ack_b, exp_ack); end
            total++; if (en_n_b !== !in_acc) begin bad++; $display("FAIL rand_en_n cyc=%0d got=%b exp=%b", i, en_n_b, !in_acc); end
            total++; if (oe_n_b !== !(in_acc && !m_we)) begin bad++; $display("FAIL rand_oe_n cyc=%0d got=%b exp=%b", i, oe_n_b, !(in_acc && !m_we)); end
            total++; if (we_n_b !== !(in_acc && m_we)) begin bad++; $display("FAIL rand_we_n cyc=%0d got=%b exp=%b", i, we_n_b, !(in_acc && m_we)); end
            total++; if (dq_oe_b !== (m_we && i >= m_g && i <= m_g + WB)) begin bad++; $display("FAIL rand_dq_oe cyc=%0d got=%b", i, dq_oe_b); end
            total++; if (busy_b !== (pend & ~exp_ack)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy_b, pend & ~exp_ack); end
            if (i >= m_g && i <= m_g + WB) begin
                total++; if (saddr_b !== m_addr) begin bad++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, saddr_b, m_addr); end
                if (m_we) begin
                    total++; if (dq_o_b !== m_wd) begin bad++; $display("FAIL rand_dq_o cyc=%0d got=%h exp=%h", i, dq_o_b, m_wd); end
                end
            end
            if (i == m_ack) begin
                if (m_we) exp_mem_b[m_addr] = m_wd;
                else begin
                    total++; if (rdata_b !== exp_rd_b(m_addr)) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, rdata_b, exp_rd_b(m_addr)); end
                end
            end
            for (int c = 0; c < NB; c++) begin
                if (pend[c] && exp_ack[c]) begin
                    pend[c] = 1'b0; gap[c] = $urandom_range(0, 3);
                end
                if (!pend[c]) begin
                    if (gap[c] == 0) begin
                        pend[c] = 1'b1;
                        cw[c] = 1'($urandom_range(0, 1));
                        ca[c] = AW'($urandom_range(0, 7));
                        cd[c] = DW'($urandom);
                    end else gap[c]--;
                end
                req_b[c] = pend[c];
                we_b[c] = cw[c];
                addr_b[c*AW +: AW] = ca[c];
                wdata_b[c*DW +: DW] = cd[c];
            end
            if ((i + 1) >= m_free && pend != '0) begin
                g = -1;
                for (int k = 0; k < NB; k++) if (g < 0 && pend[(ptr + k) % NB]) g = (ptr + k) % NB;
                m_ch = g; m_g = i + 1; m_ack = i + 1 + WB; m_free = i + 1 + WB + 2;
                m_we = cw[g]; m_addr = ca[g]; m_wd = cd[g];
                ptr = (g + 1) % NB;
            end
        end
        req_b = '0;
        repeat (WB + 4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fixed_priority();
        test_reset_mid_write();
        test_round_robin();
        test_req_dropped();
        test_random_rr(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised multi-requester controller for one asynchronous single-port SRAM chip, such as the board's Ram1 and Ram2 devices.
- Successor to the current single-client RAM wrapper. It arbitrates NUM_CH pipeline clients (for example MEM-stage data access and IF-stage fetch) onto one chip.
- Runs a multi-cycle read/write timing FSM and exposes a per-channel req/ack handshake plus busy outputs that the hazard unit uses to stall the pipeline.
- Sits between the pipeline stages and the top-level SRAM pins; the tristate buffer stays at top level.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- NUM_CH, 2, number of requesting channels (min 1, max 8); channel 0 is the MEM stage.
- WAIT_CYCLES, 1, cycles the strobe is held active (min 1).
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel request level; held high until ack.
- we  in  NUM_CH  per-channel write enable (1 = write), sampled with req.
- addr  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  flattened write data, same packing.
- ack  out  NUM_CH  one-cycle completion pulse, one-hot.
- rdata  out  DATA_W  read data, valid while the matching ack is high.
- busy  out  NUM_CH  req[i] & ~ack[i]; combinational, feeds hazard stall.
- sram_addr  out  ADDR_W  registered SRAM address.
- sram_dq_o  out  DATA_W  registered data to drive onto the bus.
- sram_dq_oe  out  1  drive enable for the top-level tristate buffer.
- sram_dq_i  in  DATA_W  bus value sampled from the pins.
- sram_en_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset values (all outputs):
  - state = IDLE; ack = 0; rdata = 0.
  - sram_en_n = 1, sram_oe_n = 1, sram_we_n = 1, sram_dq_oe = 0.
  - sram_addr = 0, sram_dq_o = 0.
  - Round-robin pointer = 0.
- Reset mid-transaction:
  - Aborts at that edge; all strobes go inactive on the same edge.
  - No ack is issued for the aborted access.
- State machine (IDLE, ACCESS, DONE):
- IDLE:
  - If any req is set, pick a grant index g.
  - Latch addr[g], wdata[g], we[g] into sram_addr, sram_dq_o and an internal op flag.
  - Go to ACCESS and load wait counter = WAIT_CYCLES-1.
  - If no req is set, stay in IDLE with all strobes inactive.
- ACCESS:
  - sram_en_n = 0 throughout.
  - Read: sram_oe_n = 0.
  - Write: sram_we_n = 0 and sram_dq_oe = 1.
  - Counter decrements each cycle. At counter == 0:
    - Read: capture sram_dq_i into rdata.
    - Go to DONE.
- DONE:
  - ack[g] = 1 for exactly this cycle; all strobes inactive.
  - Write: sram_dq_oe stays 1 for one data-hold cycle after WE rises.
  - Go to IDLE unconditionally.
- Latency and throughput:
  - Req seen in IDLE at edge N gives ack high during cycle N+WAIT_CYCLES+1.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Arbitration:
  - ARB_MODE 0: grant the lowest set index.
  - ARB_MODE 1: grant the first set index at or after the pointer, searching with wrap-around. On each grant the pointer becomes (g+1) mod NUM_CH.
- Handshake rules:
  - Once granted, the transaction is committed.
  - If req[g] drops mid-access, the access still completes and ack still pulses.
  - Ungranted requests wait; their busy stays 1.
  - New requests arriving during ACCESS/DONE are evaluated in the next IDLE.
- Bus contention: sram_oe_n = 0 and sram_dq_oe = 1 are never both true in the same cycle; assert this in the bench.
- Address path: sram_addr and sram_dq_o change only on the IDLE→ACCESS edge and are stable through DONE.

Decomposition:
- Package sram_arb_pkg:
  - State encoding constants (IDLE, ACCESS, DONE).
  - ARB_FIXED = 0 and ARB_RR = 1.
  - Default width constants (18/16).
- Sub-module arb_pick: combinational picker.
  - Inputs: req vector, pointer, mode.
  - Outputs: grant index and valid.
  - Reused by the planned I/O-port arbiter.

Test Plan:
- Single read, WAIT_CYCLES=1: ch0 reads addr 0x00010 with the bus model returning 0xBEEF. Required: oe_n low for 1 cycle, ack[0] two cycles after req, rdata = 0xBEEF.
- Single write: ch1 writes 0x1234 to addr 0x3FFFF (max address). Required: we_n low exactly WAIT_CYCLES cycles, dq_oe high for WAIT_CYCLES+1 cycles, sram_addr = 0x3FFFF, model memory holds 0x1234.
- Fixed priority: ch0 and ch1 request in the same cycle (ARB_MODE 0). Required: ch0 acked first, ch1 acked 3 cycles later, busy[1] high throughout the wait.
- Round-robin: NUM_CH=3, all requesting continuously (ARB_MODE 1). Required: ack order 0,1,2,0,1,2; no channel waits more than 2 grants.
- Reset mid-write: rst asserted in the ACCESS cycle. Required: next cycle we_n = 1, dq_oe = 0, no ack, state IDLE; a fresh read then completes normally.
- Req dropped: ch0 deasserts req during ACCESS with WAIT_CYCLES=3. Required: access still runs 3 strobe cycles and ack[0] still pulses once.
